// File: rtl/lfsr_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_stream_gen
// Purpose  : Runtime-configurable LFSR stream generator. Length, tap mask,
//            seed and mode (Galois / Fibonacci) are loaded at runtime; the
//            register advances OUT_W steps per produced word and words are
//            delivered over a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_stream_gen #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 8,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK_I,
    input  logic             RST_N_I,
    input  logic             LOAD_I,
    input  logic [WIDTH-1:0] SEED_I,
    input  logic [WIDTH-1:0] POLY_I,
    input  logic [LW-1:0]    LEN_I,
    input  logic             MODE_I,
    input  logic             EN_I,
    input  logic             READY_I,
    output logic [OUT_W-1:0] DATA_O,
    output logic             VALID_O,
    output logic [WIDTH-1:0] STATE_O,
    output logic             ERR_O,
    output logic [31:0]      CNT_O
);

    // Controller states
    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_CHECK = 2'd1;
    localparam logic [1:0] C_RUN   = 2'd2;
    localparam logic [1:0] C_ERR   = 2'd3;

    // Legal range of the active length
    localparam logic [LW-1:0] C_LEN_MIN = LW'(2);
    localparam logic [LW-1:0] C_LEN_MAX = LW'(WIDTH);

    // Reset synchroniser: assertion is immediate, release is clock-aligned
    logic [1:0]       r_rst_sync;
    logic             w_rst_n;

    // Captured configuration
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_poly;
    logic [LW-1:0]    r_len;
    logic             r_mode;

    // Datapath / controller registers
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_lfsr;
    logic [OUT_W-1:0] r_data;
    logic             r_valid;
    logic             r_err;
    logic [31:0]      r_cnt;

    // Next-state values
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_lfsr_nxt;
    logic [OUT_W-1:0] w_data_nxt;
    logic             w_valid_nxt;
    logic             w_err_nxt;
    logic [31:0]      w_cnt_nxt;

    // Length-derived masks and config checks
    logic [WIDTH-1:0] w_len_mask;
    logic [WIDTH-1:0] w_top_bit;
    logic [WIDTH-1:0] w_poly_m;
    logic [WIDTH-1:0] w_seed_m;
    logic             w_len_ok;
    logic             w_tap_ok;
    logic             w_cfg_ok;

    // Word build
    logic [WIDTH-1:0] w_walk;
    logic [OUT_W-1:0] w_word;
    logic             w_slot_free;

    // One LFSR step. Bits at or above LEN stay zero because the input
    // register and the tap mask are both already masked to LEN.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] r,
        input logic             fib,
        input logic [WIDTH-1:0] poly_m,
        input logic [WIDTH-1:0] top
    );
        logic [WIDTH-1:0] shifted;
        shifted = r >> 1;
        if (fib) begin
            f_step = (^(r & poly_m)) ? (shifted | top) : shifted;
        end else begin
            f_step = r[0] ? (shifted ^ poly_m) : shifted;
        end
    endfunction

    // Two-flop reset synchroniser feeding every other register
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // One-hot position of LEN-1 and the active-bit mask, per bit
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign w_len_mask[gi] = (r_len > LW'(gi));
        assign w_top_bit[gi]  = (r_len == LW'(gi + 1));
    end

    assign w_poly_m = r_poly & w_len_mask;
    assign w_seed_m = r_seed & w_len_mask;
    assign w_len_ok = (r_len >= C_LEN_MIN) && (r_len <= C_LEN_MAX);
    // Galois needs the top tap, Fibonacci needs the bit-0 tap
    assign w_tap_ok = r_mode ? r_poly[0] : (|(r_poly & w_top_bit));
    assign w_cfg_ok = w_len_ok && w_tap_ok && (|w_seed_m);

    assign w_slot_free = !r_valid || READY_I;

    // Chain OUT_W steps in one cycle; step k output lands in word bit k
    always_comb begin
        w_walk = r_lfsr;
        w_word = '0;
        for (int k = 0; k < OUT_W; k++) begin
            w_word[k] = w_walk[0];
            w_walk    = f_step(w_walk, r_mode, w_poly_m, w_top_bit);
        end
    end

    // Latch the configuration on every load so CHECK sees a stable copy
    always_ff @(posedge CLK_I or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_seed <= '0;
            r_poly <= '0;
            r_len  <= '0;
            r_mode <= 1'b0;
        end else if (LOAD_I) begin
            r_seed <= SEED_I;
            r_poly <= POLY_I;
            r_len  <= LEN_I;
            r_mode <= MODE_I;
        end
    end

    // Next-state and output decode; a load pre-empts every state
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        if (LOAD_I) begin
            // A handshake in this cycle still completes at the consumer, but
            // the count restarts and any pending word is discarded.
            w_state_nxt = C_CHECK;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_lfsr_nxt  = '0;
        end else begin
            if (r_valid && READY_I) begin
                w_cnt_nxt = r_cnt + 32'd1;
            end
            case (r_state)
                C_IDLE: begin
                    w_valid_nxt = 1'b0;
                end
                C_CHECK: begin
                    w_valid_nxt = 1'b0;
                    if (w_cfg_ok) begin
                        w_state_nxt = C_RUN;
                        w_lfsr_nxt  = w_seed_m;
                        w_err_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = C_ERR;
                        w_err_nxt   = 1'b1;
                    end
                end
                C_RUN: begin
                    // A held word leaves data, register and valid untouched
                    if (w_slot_free) begin
                        if (EN_I) begin
                            w_data_nxt  = w_word;
                            w_valid_nxt = 1'b1;
                            w_lfsr_nxt  = w_walk;
                        end else begin
                            w_valid_nxt = 1'b0;
                        end
                    end
                end
                C_ERR: begin
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = C_IDLE;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge CLK_I or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= C_IDLE;
            r_lfsr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign DATA_O  = r_data;
    assign VALID_O = r_valid;
    assign STATE_O = r_lfsr;
    assign ERR_O   = r_err;
    assign CNT_O   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_stream_gen
// Purpose  : Self-checking bench for lfsr_stream_gen: directed vectors plus a
//            word-level reference model checked on every handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_stream_gen;

    localparam int WIDTH = 32;
    localparam int OUT_W = 8;
    localparam int LW    = $clog2(WIDTH + 1);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             load  = 1'b0;
    logic [WIDTH-1:0] seed  = '0;
    logic [WIDTH-1:0] poly  = '0;
    logic [LW-1:0]    len   = '0;
    logic             mode  = 1'b0;
    logic             en    = 1'b0;
    logic             ready = 1'b0;

    logic [OUT_W-1:0] data;
    logic             valid;
    logic [WIDTH-1:0] state;
    logic             err;
    logic [31:0]      cnt;

    logic [0:0]       data1;
    logic             valid1;
    logic [WIDTH-1:0] state1;
    logic             err1;
    logic [31:0]      cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_reg;
    logic [31:0] m_poly;
    int          m_len;
    logic        m_mode;
    logic        m_cfg_ok;
    logic [31:0] m_cnt;
    logic        m_err;
    int          m_since;
    logic        m_hold;
    logic [OUT_W-1:0] m_hold_data;
    logic [31:0] m_hold_state;

    // Hand-computed single-step Fibonacci outputs (LEN 4, taps 0011, seed 1)
    logic [31:0] fib_s [0:4] = '{32'h8, 32'h4, 32'h2, 32'h9, 32'hC};
    logic [31:0] fib_d [0:4] = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h1};

    always #5 clk = ~clk;

    lfsr_stream_gen #(.WIDTH(WIDTH), .OUT_W(OUT_W), .LW(LW)) u_dut (
        .CLK_I   (clk),
        .RST_N_I (rst_n),
        .LOAD_I  (load),
        .SEED_I  (seed),
        .POLY_I  (poly),
        .LEN_I   (len),
        .MODE_I  (mode),
        .EN_I    (en),
        .READY_I (ready),
        .DATA_O  (data),
        .VALID_O (valid),
        .STATE_O (state),
        .ERR_O   (err),
        .CNT_O   (cnt)
    );

    lfsr_stream_gen #(.WIDTH(WIDTH), .OUT_W(1), .LW(LW)) u_dut1 (
        .CLK_I   (clk),
        .RST_N_I (rst_n),
        .LOAD_I  (load),
        .SEED_I  (seed),
        .POLY_I  (poly),
        .LEN_I   (len),
        .MODE_I  (mode),
        .EN_I    (en),
        .READY_I (ready),
        .DATA_O  (data1),
        .VALID_O (valid1),
        .STATE_O (state1),
        .ERR_O   (err1),
        .CNT_O   (cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mask_of(input int l);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < l && i < 32; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic cfg_ok(input logic [31:0] s, input logic [31:0] p,
                                    input int l, input logic fib);
        if (l < 2 || l > WIDTH) return 1'b0;
        if (fib && !p[0]) return 1'b0;
        if (!fib && !p[l-1]) return 1'b0;
        if ((s & mask_of(l)) == 32'h0) return 1'b0;
        return 1'b1;
    endfunction

    // Produce the next word from the model register using the step rules
    function automatic void model_word(input logic [31:0] r_in,
                                       output logic [OUT_W-1:0] w,
                                       output logic [31:0] r_out);
        logic [31:0] r;
        logic [31:0] pm;
        logic        o;
        logic        fb;
        r  = r_in;
        pm = m_poly & mask_of(m_len);
        w  = '0;
        for (int k = 0; k < OUT_W; k++) begin
            o    = r[0];
            w[k] = o;
            if (m_mode) begin
                fb = ^(r & pm);
                r  = r >> 1;
                r[m_len-1] = fb;
            end else begin
                r = r >> 1;
                if (o) r = r ^ pm;
            end
        end
        r_out = r;
    endfunction

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin : p_cmp
        logic [OUT_W-1:0] ew;
        logic [31:0]      er;
        if (!rst_n) begin
            chk("rst_data",  32'(data),  32'h0);
            chk("rst_valid", 32'(valid), 32'h0);
            chk("rst_state", state,      32'h0);
            chk("rst_err",   32'(err),   32'h0);
            chk("rst_cnt",   cnt,        32'h0);
            m_cnt    = '0;
            m_err    = 1'b0;
            m_since  = 100;
            m_cfg_ok = 1'b0;
            m_hold   = 1'b0;
        end else begin
            chk("cnt_model", cnt, m_cnt);
            chk("err_model", 32'(err), 32'(m_err));
            if (m_since < 2 || !m_cfg_ok) chk("valid_quiet", 32'(valid), 32'h0);
            if (m_hold) begin
                chk("hold_valid", 32'(valid), 32'h1);
                chk("hold_data",  32'(data),  32'(m_hold_data));
                chk("hold_state", state,      m_hold_state);
            end
            if (valid && ready) begin
                model_word(m_reg, ew, er);
                chk("word_data",  32'(data), 32'(ew));
                chk("word_state", state,     er);
                m_reg = er;
                m_cnt = m_cnt + 32'd1;
            end
            m_hold       = valid && !ready && !load;
            m_hold_data  = data;
            m_hold_state = state;
            if (load) begin
                m_cnt    = '0;
                m_since  = 0;
                m_len    = int'(len);
                m_poly   = poly;
                m_mode   = mode;
                m_cfg_ok = cfg_ok(seed, poly, int'(len), mode);
                m_reg    = seed & mask_of(int'(len));
            end else if (m_since < 100) begin
                m_since = m_since + 1;
                if (m_since == 1) m_err = !m_cfg_ok;
            end
        end
    end

    task automatic do_load(input logic [31:0] s, input logic [31:0] p,
                           input int l, input logic fib);
        @(posedge clk); #1;
        load = 1'b1;
        seed = s;
        poly = p;
        len  = LW'(l);
        mode = fib;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic bad_load(input string name, input logic [31:0] s,
                            input logic [31:0] p, input int l);
        do_load(s, p, l, 1'b0);
        repeat (3) @(negedge clk);
        chk({name, "_err"},   32'(err),   32'h1);
        chk({name, "_valid"}, 32'(valid), 32'h0);
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : p_stim
        logic [31:0] c0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Galois LEN 4, taps 1100, seed 1: first word timing and contents
        do_load(32'h1, 32'hC, 4, 1'b0);
        @(negedge clk); chk("gal_valid_n0", 32'(valid), 32'h0);
        @(negedge clk); chk("gal_valid_n1", 32'(valid), 32'h0);
        @(negedge clk); chk("gal_valid_n2", 32'(valid), 32'h1);
        chk("gal_w0_data", 32'(data), 32'h59);
        chk("gal_w0_state", state, 32'h7);
        @(negedge clk);
        chk("gal_w1_data", 32'(data), 32'h8F);
        chk("gal_w1_state", state, 32'hC);
        for (int i = 2; i <= 15; i++) begin
            @(negedge clk);
            if (i == 15) chk("gal_period", state, 32'h7);
            else chk("gal_early_repeat", 32'(state == 32'h7), 32'h0);
        end

        // Backpressure: freeze for several cycles, count only handshakes
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        c0 = cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_cnt_frozen", cnt, c0);
            chk("bp_valid_held", 32'(valid), 32'h1);
        end
        @(posedge clk); #1;
        ready = 1'b1;
        @(negedge clk); chk("bp_cnt_resume0", cnt, c0);
        @(negedge clk); chk("bp_cnt_resume1", cnt, c0 + 32'd1);

        // Enable gating: valid follows EN one cycle later
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            en = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("en_toggle_valid", 32'(valid), (i % 2 == 0) ? 32'h1 : 32'h0);
        end

        // Fibonacci LEN 4, taps 0011, seed 1
        do_load(32'h1, 32'h3, 4, 1'b1);
        @(negedge clk); chk("fib_valid_n0", 32'(valid), 32'h0);
        @(negedge clk); chk("fib_valid_n1", 32'(valid), 32'h0);
        for (int j = 0; j <= 15; j++) begin
            @(negedge clk);
            if (j == 0) begin
                chk("fib_w0_data", 32'(data), 32'h91);
                chk("fib_w0_state", state, 32'h5);
            end
            if (j <= 4) begin
                chk("fib1_data", 32'(data1), fib_d[j]);
                chk("fib1_state", state1, fib_s[j]);
            end else if (j == 15) begin
                chk("fib1_period", state1, 32'h8);
            end else begin
                chk("fib1_early_repeat", 32'(state1 == 32'h8), 32'h0);
            end
        end

        // Rejected configurations, then recovery
        bad_load("bad_seed0", 32'h0, 32'hC, 4);
        bad_load("bad_len1",  32'h1, 32'h1, 1);
        bad_load("bad_gtap",  32'h1, 32'h6, 4);
        do_load(32'h1, 32'hC, 4, 1'b0);
        @(negedge clk); chk("recover_err_check", 32'(err), 32'h1);
        @(negedge clk); chk("recover_err_clear", 32'(err), 32'h0);
        @(negedge clk);
        chk("recover_data", 32'(data), 32'h59);
        chk("recover_valid", 32'(valid), 32'h1);

        // Load while a word is held: word dropped, new stream from seed 8
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk); chk("drop_held", 32'(valid), 32'h1);
        do_load(32'h8, 32'hC, 4, 1'b0);
        ready = 1'b1;
        @(negedge clk);
        chk("drop_cnt", cnt, 32'h0);
        chk("drop_valid", 32'(valid), 32'h0);
        @(negedge clk); chk("drop_valid_n1", 32'(valid), 32'h0);
        @(negedge clk);
        chk("drop_new_data", 32'(data), 32'hC8);
        chk("drop_new_state", state, 32'hA);

        // Load coinciding with a handshake: consumed, counter cleared
        do_load(32'h1, 32'hC, 4, 1'b0);
        @(negedge clk); chk("hs_load_cnt", cnt, 32'h0);
        @(negedge clk);
        @(negedge clk); chk("hs_load_data", 32'(data), 32'h59);

        // Reset mid-stream: outputs clear without waiting for a clock
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data",  32'(data),  32'h0);
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_state", state,      32'h0);
        chk("arst_cnt",   cnt,        32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_valid", 32'(valid), 32'h0);
            chk("idle_state", state, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
